// File: rtl/mythcore_run_monitor_if.sv
// Bus between the run monitor and its environment: run request, target value,
// the core result bus, and the monitor's reset/status/counter outputs.
interface mythcore_run_monitor_if #(
  parameter int OUT_W = 10,
  parameter int CNT_W = 16
);
  // start is a one-cycle request with no ready: it is taken only in IDLE or
  // DONE (busy low) and dropped otherwise; expected is sampled on that edge only.
  logic             start;
  logic [OUT_W-1:0] expected;
  logic [OUT_W-1:0] core_out;
  logic             core_reset;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] changes;
  logic [OUT_W-1:0] last_out;

  modport master (
    output start, expected, core_out,
    input  core_reset, busy, done, pass, cycles, changes, last_out
  );

  modport slave (
    input  start, expected, core_out,
    output core_reset, busy, done, pass, cycles, changes, last_out
  );
endinterface

// File: rtl/mythcore_run_monitor.sv
// Run controller for the RVMyth core: holds core reset for a counted window,
// then watches the result bus until a held match (pass) or a cycle timeout.
module mythcore_run_monitor #(
  parameter int OUT_W      = 10,
  parameter int RST_CYCLES = 5,
  parameter int TIMEOUT    = 1000,
  parameter int MATCH_HOLD = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mythcore_run_monitor_if.slave mon,
  output logic [1:0]            state_dbg
);

  localparam int HC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int MC_W = $clog2(MATCH_HOLD + 1);

  localparam logic [HC_W-1:0]  HOLD_LAST  = HC_W'(RST_CYCLES - 1);
  localparam logic [MC_W-1:0]  MATCH_LAST = MC_W'(MATCH_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);

  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("RST_CYCLES must be at least 1");
  end
  if (MATCH_HOLD < 1) begin : g_bad_hold
    $error("MATCH_HOLD must be at least 1");
  end
  if (TIMEOUT < MATCH_HOLD || longint'(TIMEOUT) >= (longint'(1) << CNT_W)) begin : g_bad_to
    $error("TIMEOUT must be >= MATCH_HOLD and fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q,      state_d;
  logic             core_reset_q, core_reset_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic             pass_q,       pass_d;
  logic [CNT_W-1:0] cycles_q,     cycles_d;
  logic [CNT_W-1:0] changes_q,    changes_d;
  logic [OUT_W-1:0] last_out_q,   last_out_d;
  logic [MC_W-1:0]  match_cnt_q,  match_cnt_d;
  logic [HC_W-1:0]  hold_cnt_q,   hold_cnt_d;
  logic [OUT_W-1:0] exp_q,        exp_d;
  logic             match;

  always_comb begin
    state_d      = state_q;
    core_reset_d = core_reset_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    cycles_d     = cycles_q;
    changes_d    = changes_q;
    last_out_d   = last_out_q;
    match_cnt_d  = match_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    exp_d        = exp_q;
    match        = (mon.core_out == exp_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (mon.start) begin
          state_d      = S_HOLD;
          core_reset_d = 1'b1;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
          cycles_d     = '0;
          changes_d    = '0;
          last_out_d   = '0;
          match_cnt_d  = '0;
          hold_cnt_d   = '0;
          exp_d        = mon.expected;
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d      = S_RUN;
          core_reset_d = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      S_RUN: begin
        cycles_d   = cycles_q + CNT_W'(1);
        last_out_d = mon.core_out;
        if (mon.core_out != last_out_q && changes_q != '1) begin
          changes_d = changes_q + CNT_W'(1);
        end
        match_cnt_d = match ? match_cnt_q + MC_W'(1) : '0;
        // A held match on the timeout cycle still counts as a pass.
        if ((match && match_cnt_q == MATCH_LAST) || cycles_q == TO_LAST) begin
          state_d      = S_DONE;
          core_reset_d = 1'b1;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          pass_d       = match && (match_cnt_q == MATCH_LAST);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      cycles_q     <= '0;
      changes_q    <= '0;
      last_out_q   <= '0;
      match_cnt_q  <= '0;
      hold_cnt_q   <= '0;
      exp_q        <= '0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      cycles_q     <= cycles_d;
      changes_q    <= changes_d;
      last_out_q   <= last_out_d;
      match_cnt_q  <= match_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      exp_q        <= exp_d;
    end
  end

  assign mon.core_reset = core_reset_q;
  assign mon.busy       = busy_q;
  assign mon.done       = done_q;
  assign mon.pass       = pass_q;
  assign mon.cycles     = cycles_q;
  assign mon.changes    = changes_q;
  assign mon.last_out   = last_out_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_mythcore_run_monitor.sv
// Directed bench for mythcore_run_monitor: default instance plus a
// TIMEOUT=MATCH_HOLD=4 instance for the pass/timeout coincidence.
module tb_mythcore_run_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] state_dbg;
  logic [1:0] state5_dbg;

  always #5 clk = ~clk;

  mythcore_run_monitor_if #(.OUT_W(10), .CNT_W(16)) ifc ();
  mythcore_run_monitor_if #(.OUT_W(10), .CNT_W(16)) ifc5 ();

  mythcore_run_monitor u_dut (
    .clk       (clk),
    .reset     (reset),
    .mon       (ifc.slave),
    .state_dbg (state_dbg)
  );

  mythcore_run_monitor #(.TIMEOUT(4), .MATCH_HOLD(4)) u_dut5 (
    .clk       (clk),
    .reset     (reset),
    .mon       (ifc5.slave),
    .state_dbg (state5_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.start = 1'b0; ifc.expected = '0; ifc.core_out = '0;
    ifc5.start = 1'b0; ifc5.expected = '0; ifc5.core_out = '0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (ifc.core_reset !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle_flags cyc %0d: core_reset=%b busy=%b done=%b, want 1 0 0", i, ifc.core_reset, ifc.busy, ifc.done);
      end
    end
    checks++;
    if (ifc.cycles !== 16'd0 || ifc.changes !== 16'd0 || ifc.last_out !== 10'd0 || ifc.pass !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: cycles=%0d changes=%0d last_out=%0h pass=%b, want 0 0 0 0", ifc.cycles, ifc.changes, ifc.last_out, ifc.pass);
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
  endtask

  task automatic test_match();
    ifc.expected = 10'h0AA; ifc.core_out = 10'h000; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0; ifc.expected = 10'h000;
    checks++;
    if (ifc.busy !== 1'b1 || ifc.core_reset !== 1'b1 || state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL match_enter_hold: busy=%b core_reset=%b state=%0d, want 1 1 1", ifc.busy, ifc.core_reset, state_dbg);
    end
    for (int i = 1; i < 5; i++) begin
      tick();
      checks++;
      if (ifc.core_reset !== 1'b1) begin
        errors++;
        $display("FAIL match_hold_len hold %0d: core_reset=%b want 1", i, ifc.core_reset);
      end
    end
    tick();
    checks++;
    if (ifc.core_reset !== 1'b0 || ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL match_run_entry: core_reset=%b busy=%b, want 0 1", ifc.core_reset, ifc.busy);
    end
    tick();
    ifc.core_out = 10'h0AA;
    checks++;
    if (ifc.cycles !== 16'd1 || ifc.changes !== 16'd0) begin
      errors++;
      $display("FAIL match_first_run: cycles=%0d changes=%0d, want 1 0", ifc.cycles, ifc.changes);
    end
    repeat (3) tick();
    checks++;
    if (ifc.done !== 1'b0) begin
      errors++;
      $display("FAIL match_early_done: done=%b want 0", ifc.done);
    end
    tick();
    checks++;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b1 || ifc.cycles !== 16'd5 || ifc.changes !== 16'd1) begin
      errors++;
      $display("FAIL match_pass: done=%b pass=%b cycles=%0d changes=%0d, want 1 1 5 1", ifc.done, ifc.pass, ifc.cycles, ifc.changes);
    end
    checks++;
    if (ifc.core_reset !== 1'b1 || ifc.busy !== 1'b0 || ifc.last_out !== 10'h0AA) begin
      errors++;
      $display("FAIL match_done_outs: core_reset=%b busy=%b last_out=%0h, want 1 0 0aa", ifc.core_reset, ifc.busy, ifc.last_out);
    end
    ifc.core_out = 10'h3C3;
    repeat (3) tick();
    checks++;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b1 || ifc.cycles !== 16'd5 || ifc.last_out !== 10'h0AA) begin
      errors++;
      $display("FAIL match_frozen: done=%b pass=%b cycles=%0d last_out=%0h, want 1 1 5 0aa", ifc.done, ifc.pass, ifc.cycles, ifc.last_out);
    end
  endtask

  task automatic test_timeout();
    ifc.expected = 10'h0AA; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    checks++;
    if (ifc.done !== 1'b0 || ifc.cycles !== 16'd0) begin
      errors++;
      $display("FAIL timeout_restart: done=%b cycles=%0d, want 0 0", ifc.done, ifc.cycles);
    end
    repeat (5) tick();
    for (int i = 0; i < 1000; i++) begin
      ifc.core_out = (i % 2 == 1) ? 10'h0AB : 10'h0AA;
      tick();
      if (i == 998) begin
        checks++;
        if (ifc.done !== 1'b0 || ifc.cycles !== 16'd999) begin
          errors++;
          $display("FAIL timeout_early: done=%b cycles=%0d, want 0 999", ifc.done, ifc.cycles);
        end
      end
    end
    checks++;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b0 || ifc.cycles !== 16'd1000) begin
      errors++;
      $display("FAIL timeout_done: done=%b pass=%b cycles=%0d, want 1 0 1000", ifc.done, ifc.pass, ifc.cycles);
    end
    checks++;
    if (ifc.changes !== 16'd1000 || ifc.last_out !== 10'h0AB || ifc.core_reset !== 1'b1) begin
      errors++;
      $display("FAIL timeout_stats: changes=%0d last_out=%0h core_reset=%b, want 1000 0ab 1", ifc.changes, ifc.last_out, ifc.core_reset);
    end
  endtask

  task automatic test_reset_mid();
    ifc.expected = 10'h0AA; ifc.core_out = 10'h3FF; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (5) tick();
    repeat (49) tick();
    checks++;
    if (ifc.cycles !== 16'd49 || ifc.core_reset !== 1'b0) begin
      errors++;
      $display("FAIL midreset_pre: cycles=%0d core_reset=%b, want 49 0", ifc.cycles, ifc.core_reset);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ifc.core_reset !== 1'b1 || ifc.cycles !== 16'd0 || ifc.busy !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL midreset_idle: core_reset=%b cycles=%0d busy=%b state=%0d, want 1 0 0 0", ifc.core_reset, ifc.cycles, ifc.busy, state_dbg);
    end
    checks++;
    if (ifc.changes !== 16'd0 || ifc.last_out !== 10'd0 || ifc.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: changes=%0d last_out=%0h done=%b, want 0 0 0", ifc.changes, ifc.last_out, ifc.done);
    end
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (4) tick();
    checks++;
    if (ifc.core_reset !== 1'b1 || ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_hold: core_reset=%b busy=%b, want 1 1", ifc.core_reset, ifc.busy);
    end
    tick();
    checks++;
    if (ifc.core_reset !== 1'b0 || ifc.cycles !== 16'd0) begin
      errors++;
      $display("FAIL midreset_run: core_reset=%b cycles=%0d, want 0 0", ifc.core_reset, ifc.cycles);
    end
  endtask

  task automatic test_back_to_back();
    // Still in RUN with exp 0AA; a start here must not reload 155.
    ifc.core_out = 10'h0AA; ifc.expected = 10'h155; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0; ifc.expected = 10'h000;
    repeat (3) tick();
    checks++;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b1 || ifc.cycles !== 16'd4 || ifc.changes !== 16'd1) begin
      errors++;
      $display("FAIL b2b_run_start_ignored: done=%b pass=%b cycles=%0d changes=%0d, want 1 1 4 1", ifc.done, ifc.pass, ifc.cycles, ifc.changes);
    end
    ifc.expected = 10'h155; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0; ifc.expected = 10'h000;
    checks++;
    if (ifc.done !== 1'b0 || ifc.pass !== 1'b0 || ifc.busy !== 1'b1 || state_dbg !== 2'd1 || ifc.cycles !== 16'd0) begin
      errors++;
      $display("FAIL b2b_restart: done=%b pass=%b busy=%b state=%0d cycles=%0d, want 0 0 1 1 0", ifc.done, ifc.pass, ifc.busy, state_dbg, ifc.cycles);
    end
    tick();
    ifc.expected = 10'h0AA; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0; ifc.expected = 10'h000;
    repeat (2) tick();
    checks++;
    if (ifc.core_reset !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold_start_ignored: core_reset=%b want 1", ifc.core_reset);
    end
    tick();
    checks++;
    if (ifc.core_reset !== 1'b0) begin
      errors++;
      $display("FAIL b2b_hold_len: core_reset=%b want 0", ifc.core_reset);
    end
    ifc.core_out = 10'h155;
    repeat (4) tick();
    checks++;
    if (ifc.done !== 1'b1 || ifc.pass !== 1'b1 || ifc.cycles !== 16'd4 || ifc.changes !== 16'd1 || ifc.last_out !== 10'h155) begin
      errors++;
      $display("FAIL b2b_new_expected: done=%b pass=%b cycles=%0d changes=%0d last_out=%0h, want 1 1 4 1 155", ifc.done, ifc.pass, ifc.cycles, ifc.changes, ifc.last_out);
    end
  endtask

  task automatic test_coincide();
    ifc5.expected = 10'h2F0; ifc5.core_out = 10'h2F0; ifc5.start = 1'b1;
    tick();
    ifc5.start = 1'b0;
    repeat (5) tick();
    checks++;
    if (ifc5.core_reset !== 1'b0) begin
      errors++;
      $display("FAIL coincide_run: core_reset=%b want 0", ifc5.core_reset);
    end
    repeat (3) tick();
    checks++;
    if (ifc5.done !== 1'b0) begin
      errors++;
      $display("FAIL coincide_early: done=%b want 0", ifc5.done);
    end
    tick();
    checks++;
    if (ifc5.done !== 1'b1 || ifc5.pass !== 1'b1 || ifc5.cycles !== 16'd4 || ifc5.changes !== 16'd1) begin
      errors++;
      $display("FAIL coincide_pass: done=%b pass=%b cycles=%0d changes=%0d, want 1 1 4 1", ifc5.done, ifc5.pass, ifc5.cycles, ifc5.changes);
    end
    ifc5.core_out = 10'h001; ifc5.start = 1'b1;
    tick();
    ifc5.start = 1'b0;
    repeat (9) tick();
    checks++;
    if (ifc5.done !== 1'b1 || ifc5.pass !== 1'b0 || ifc5.cycles !== 16'd4) begin
      errors++;
      $display("FAIL short_timeout: done=%b pass=%b cycles=%0d, want 1 0 4", ifc5.done, ifc5.pass, ifc5.cycles);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_match();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_coincide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
